// File: rtl/key_command_decoder_if.sv
// Key-command bus: key code/strobe from the PS/2 translator and the
// display-control state handed to the character pixel generator.
interface key_command_decoder_if #(
  parameter int OFFSET_W = 8,
  parameter int SIZE_W   = 5
);
  logic                inValid;
  logic [3:0]          inCode;
  logic [2:0]          userNum;
  logic [2:0]          outColor;
  logic [OFFSET_W-1:0] upOffset;
  logic [OFFSET_W-1:0] downOffset;
  logic [OFFSET_W-1:0] leftOffset;
  logic [OFFSET_W-1:0] rightOffset;
  logic [SIZE_W-1:0]   charSize;
  logic                enFlash;
  logic                cmdAck;

  // Key source side: drives the key strobe/code, observes display state.
  modport master (
    output inValid, inCode,
    input  userNum, outColor, upOffset, downOffset, leftOffset, rightOffset,
    input  charSize, enFlash, cmdAck
  );

  // Decoder side.
  modport slave (
    input  inValid, inCode,
    output userNum, outColor, upOffset, downOffset, leftOffset, rightOffset,
    output charSize, enFlash, cmdAck
  );
endinterface

// File: rtl/key_command_decoder.sv
// key_command_decoder: turns key presses into display control state
// (user, colour, offsets, size, flash). Each key press executes one command;
// offsets and size saturate. Define KEYCMD_AUTOREPEAT_EN to compile in the
// auto-repeat engine for motion/size codes (0x7..0xC) while a key is held.
module key_command_decoder #(
  parameter int OFFSET_W     = 8,
  parameter int OFFSET_STEP  = 1,
  parameter int SIZE_W       = 5,
  parameter int SIZE_MIN     = 1,
  parameter int SIZE_MAX     = 16,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic                 clock,
  input  logic                 reset,
  key_command_decoder_if.slave bus
);

  localparam logic [OFFSET_W:0] OFF_STEP_X = (OFFSET_W+1)'(OFFSET_STEP);
  localparam logic [OFFSET_W:0] OFF_MAX_X  = {1'b0, {OFFSET_W{1'b1}}};
  localparam logic [SIZE_W:0]   SZ_MIN_X   = (SIZE_W+1)'(SIZE_MIN);
  localparam logic [SIZE_W:0]   SZ_MAX_X   = (SIZE_W+1)'(SIZE_MAX);
  localparam logic [SIZE_W-1:0] SZ_MIN     = SIZE_W'(SIZE_MIN);

  // Offset increment, widened by one bit so the carry is seen before clamping.
  function automatic logic [OFFSET_W-1:0] sat_off_add(input logic [OFFSET_W-1:0] v);
    logic [OFFSET_W:0] sum;
    sum = {1'b0, v} + OFF_STEP_X;
    if (sum > OFF_MAX_X) sat_off_add = OFF_MAX_X[OFFSET_W-1:0];
    else                 sat_off_add = sum[OFFSET_W-1:0];
  endfunction

  // Size increment clamped at SIZE_MAX.
  function automatic logic [SIZE_W-1:0] sat_size_inc(input logic [SIZE_W-1:0] v);
    logic [SIZE_W:0] sum;
    sum = {1'b0, v} + 1'b1;
    if (sum > SZ_MAX_X) sat_size_inc = SZ_MAX_X[SIZE_W-1:0];
    else                sat_size_inc = sum[SIZE_W-1:0];
  endfunction

  // Size decrement clamped at SIZE_MIN.
  function automatic logic [SIZE_W-1:0] sat_size_dec(input logic [SIZE_W-1:0] v);
    if ({1'b0, v} <= SZ_MIN_X) sat_size_dec = SZ_MIN;
    else                       sat_size_dec = v - 1'b1;
  endfunction

  logic                prev_valid_q;
  logic [3:0]          prev_code_q;
  logic [2:0]          user_q, user_d;
  logic [2:0]          color_q, color_d;
  logic [OFFSET_W-1:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                flash_q, flash_d;
  logic                ack_q, ack_d;
  logic                press;
  logic                exec;

  // A fresh key-down or a code change while held is a press.
  assign press = bus.inValid && (!prev_valid_q || (bus.inCode != prev_code_q));

  // Remember last sampled strobe/code for press detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_valid_q <= 1'b0;
      prev_code_q  <= 4'h0;
    end else begin
      prev_valid_q <= bus.inValid;
      prev_code_q  <= bus.inCode;
    end
  end

`ifdef KEYCMD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpt_evt;
  logic             repeatable;

  assign repeatable = (bus.inCode >= 4'h7) && (bus.inCode <= 4'hC);

  // Repeat FSM state and countdown registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Repeat FSM: a press (re)arms or disarms; expiry while held issues a repeat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_evt = 1'b0;
    if (!bus.inValid) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      if (repeatable) begin
        state_d = RPT_DELAY;
        cnt_d   = DLY_LOAD;
      end else begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RPT_DELAY, RPT_REPEAT: begin
          if (cnt_q == '0) begin
            rpt_evt = 1'b1;
            state_d = RPT_REPEAT;
            cnt_d   = RATE_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = RPT_IDLE;
      endcase
    end
  end

  assign exec = press || rpt_evt;
`else
  assign exec = press;
`endif

  // Command decode: only the register named by the code changes.
  always_comb begin
    user_d  = user_q;
    color_d = color_q;
    up_d    = up_q;
    down_d  = down_q;
    left_d  = left_q;
    right_d = right_q;
    size_d  = size_q;
    flash_d = flash_q;
    ack_d   = exec;
    if (exec) begin
      case (bus.inCode)
        4'h0, 4'h1, 4'h2, 4'h3: user_d = {1'b0, bus.inCode[1:0]};
        4'h4: color_d[0] = ~color_q[0];
        4'h5: color_d[1] = ~color_q[1];
        4'h6: color_d[2] = ~color_q[2];
        4'h7: up_d    = sat_off_add(up_q);
        4'h8: down_d  = sat_off_add(down_q);
        4'h9: left_d  = sat_off_add(left_q);
        4'hA: right_d = sat_off_add(right_q);
        4'hB: size_d  = sat_size_inc(size_q);
        4'hC: size_d  = sat_size_dec(size_q);
        4'hD: flash_d = ~flash_q;
        4'hE: color_d = 3'b000;
        default: begin
          up_d    = '0;
          down_d  = '0;
          left_d  = '0;
          right_d = '0;
          size_d  = SZ_MIN;
        end
      endcase
    end
  end

  // Display control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      user_q  <= 3'd0;
      color_q <= 3'd0;
      up_q    <= '0;
      down_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      size_q  <= SZ_MIN;
      flash_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      user_q  <= user_d;
      color_q <= color_d;
      up_q    <= up_d;
      down_q  <= down_d;
      left_q  <= left_d;
      right_q <= right_d;
      size_q  <= size_d;
      flash_q <= flash_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.userNum     = user_q;
  assign bus.outColor    = color_q;
  assign bus.upOffset    = up_q;
  assign bus.downOffset  = down_q;
  assign bus.leftOffset  = left_q;
  assign bus.rightOffset = right_q;
  assign bus.charSize    = size_q;
  assign bus.enFlash     = flash_q;
  assign bus.cmdAck      = ack_q;

endmodule

// File: tb/tb_key_command_decoder.sv
// Bench for key_command_decoder: two instances (offset step 1 and 4) share
// the key stimulus; a per-step model of the command map predicts each cycle.
module tb_key_command_decoder;

`ifdef KEYCMD_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0] user;
    logic [2:0] color;
    logic [7:0] up;
    logic [7:0] down;
    logic [7:0] left;
    logic [7:0] right;
    logic [4:0] size;
    logic       flash;
    logic       ack;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_command_decoder_if #(.OFFSET_W(8), .SIZE_W(5)) ifa ();
  key_command_decoder_if #(.OFFSET_W(8), .SIZE_W(5)) ifb ();

  key_command_decoder #(.OFFSET_STEP(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_a (
    .clock(clk), .reset(rst), .bus(ifa));
  key_command_decoder #(.OFFSET_STEP(4), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_b (
    .clock(clk), .reset(rst), .bus(ifb));

  always #5 clk = ~clk;

  int     total  = 0;
  int     passed = 0;
  string  cur_tag = "reset";
  model_t ma, mb;
  model_t exp_qa[$];
  model_t exp_qb[$];
  logic   prev_v = 1'b0;
  logic [3:0] prev_c = 4'h0;

  function automatic model_t reset_model();
    model_t r;
    r.user = 0; r.color = 0; r.up = 0; r.down = 0; r.left = 0; r.right = 0;
    r.size = 5'd1; r.flash = 0; r.ack = 0;
    return r;
  endfunction

  function automatic logic [7:0] off_inc(input logic [7:0] v, input int stp);
    int s;
    s = int'(v) + stp;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  function automatic model_t apply(input model_t m, input logic ex, input logic [3:0] c, input int stp);
    model_t r;
    r = m;
    r.ack = ex;
    if (ex) begin
      case (c)
        4'h0, 4'h1, 4'h2, 4'h3: r.user = 3'(c);
        4'h4: r.color[0] = ~m.color[0];
        4'h5: r.color[1] = ~m.color[1];
        4'h6: r.color[2] = ~m.color[2];
        4'h7: r.up    = off_inc(m.up, stp);
        4'h8: r.down  = off_inc(m.down, stp);
        4'h9: r.left  = off_inc(m.left, stp);
        4'hA: r.right = off_inc(m.right, stp);
        4'hB: r.size  = (int'(m.size) >= 16) ? 5'd16 : m.size + 5'd1;
        4'hC: r.size  = (int'(m.size) <= 1) ? 5'd1 : m.size - 5'd1;
        4'hD: r.flash = ~m.flash;
        4'hE: r.color = 3'b000;
        default: begin
          r.up = 0; r.down = 0; r.left = 0; r.right = 0; r.size = 5'd1;
        end
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cmp_model(input string p, input model_t o, input model_t e);
    chk({p, ".userNum @", cur_tag},     32'(o.user),  32'(e.user));
    chk({p, ".outColor @", cur_tag},    32'(o.color), 32'(e.color));
    chk({p, ".upOffset @", cur_tag},    32'(o.up),    32'(e.up));
    chk({p, ".downOffset @", cur_tag},  32'(o.down),  32'(e.down));
    chk({p, ".leftOffset @", cur_tag},  32'(o.left),  32'(e.left));
    chk({p, ".rightOffset @", cur_tag}, 32'(o.right), 32'(e.right));
    chk({p, ".charSize @", cur_tag},    32'(o.size),  32'(e.size));
    chk({p, ".enFlash @", cur_tag},     32'(o.flash), 32'(e.flash));
    chk({p, ".cmdAck @", cur_tag},      32'(o.ack),   32'(e.ack));
  endtask

  // Pop the expected snapshots and compare against both instances.
  task automatic check_pop();
    model_t oa, ob, ea, eb;
    if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty @%s observed=0 expected=1", cur_tag);
      return;
    end
    ea = exp_qa.pop_front();
    eb = exp_qb.pop_front();
    oa.user = ifa.userNum; oa.color = ifa.outColor; oa.up = ifa.upOffset;
    oa.down = ifa.downOffset; oa.left = ifa.leftOffset; oa.right = ifa.rightOffset;
    oa.size = ifa.charSize; oa.flash = ifa.enFlash; oa.ack = ifa.cmdAck;
    ob.user = ifb.userNum; ob.color = ifb.outColor; ob.up = ifb.upOffset;
    ob.down = ifb.downOffset; ob.left = ifb.leftOffset; ob.right = ifb.rightOffset;
    ob.size = ifb.charSize; ob.flash = ifb.enFlash; ob.ack = ifb.cmdAck;
    cmp_model("A", oa, ea);
    cmp_model("B", ob, eb);
  endtask

  // One clock: drive key inputs, predict the edge, then check after it.
  task automatic step(input logic v, input logic [3:0] c, input logic rpt);
    logic press;
    ifa.inValid = v; ifa.inCode = c;
    ifb.inValid = v; ifb.inCode = c;
    press = v && (!prev_v || (c != prev_c));
    ma = apply(ma, press || (rpt && v), c, 1);
    mb = apply(mb, press || (rpt && v), c, 4);
    prev_v = v;
    prev_c = c;
    exp_qa.push_back(ma);
    exp_qb.push_back(mb);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic tap(input logic [3:0] c);
    step(1'b1, c, 1'b0);
    step(1'b0, c, 1'b0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    ma = reset_model();
    mb = reset_model();
    prev_v = 1'b0;
    prev_c = 4'h0;
    exp_qa.push_back(ma);
    exp_qb.push_back(mb);
    check_pop();
  endtask

  initial begin
    ifa.inValid = 1'b0; ifa.inCode = 4'h0;
    ifb.inValid = 1'b0; ifb.inCode = 4'h0;
    ma = reset_model();
    mb = reset_model();

    cur_tag = "reset";
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_now();
    @(negedge clk);
    rst = 1'b0;

    cur_tag = "hold_0x7";
    for (int i = 0; i < 10; i++)
      step(1'b1, 4'h7, RPT_ON && (i >= 4) && (i % 2 == 0));
    step(1'b0, 4'h7, 1'b0);

    cur_tag = "size_up";
    for (int i = 0; i < 20; i++) tap(4'hB);
    cur_tag = "size_down";
    for (int i = 0; i < 20; i++) tap(4'hC);

    cur_tag = "colour";
    tap(4'h4); tap(4'h6); tap(4'h9);
    tap(4'h4);
    tap(4'hE);

    cur_tag = "user";
    tap(4'h2); tap(4'h3); tap(4'h0);

    cur_tag = "hold_0xA";
    for (int i = 0; i < 12; i++)
      step(1'b1, 4'hA, RPT_ON && (i >= 4) && (i % 2 == 0));
    cur_tag = "switch_0xD";
    for (int i = 0; i < 6; i++) step(1'b1, 4'hD, 1'b0);
    step(1'b0, 4'hD, 1'b0);

    cur_tag = "left_sat";
    for (int i = 0; i < 65; i++) tap(4'h9);
    cur_tag = "clear_0xF";
    tap(4'hF);

    cur_tag = "reset_mid_hold";
    tap(4'hD);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    @(negedge clk);
    reset_now();
    @(negedge clk);
    rst = 1'b0;
    cur_tag = "after_reset";
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b0, 4'h8, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
